// File: rtl/decode_scoreboard_pkg.sv
// Shared opcode encodings and instruction field positions for the decode-stage
// scoreboard and its destination decoders.
package decode_scoreboard_pkg;

    typedef enum logic [4:0] {
        OP_ALU  = 5'b00000,
        OP_BNE  = 5'b00010,
        OP_JAL  = 5'b00011,
        OP_JR   = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_BLT  = 5'b00110,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b11110
    } opcode_e;

    localparam logic [4:0] LINK_REG = 5'd31;
    localparam int         FIELD_W  = 5;
    localparam int         OPC_LSB  = 27;
    localparam int         RD_LSB   = 22;
    localparam int         RS_LSB   = 17;
    localparam int         RT_LSB   = 12;

endpackage

// File: rtl/decode_scoreboard_dest_decode.sv
// Extracts whether an instruction writes a register and which one; used for
// both the decode-side push and the writeback-side pop.
module dest_decode
    import decode_scoreboard_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        writes_o,
    output logic [4:0]  dest_o
);

    logic [4:0] op;
    logic       unused_bits;

    assign op          = instr_i[OPC_LSB +: FIELD_W];
    assign unused_bits = ^instr_i[RD_LSB-1:0];

    always_comb begin
        writes_o = 1'b0;
        case (op)
            OP_ALU, OP_JAL, OP_ADDI, OP_LW, OP_SETX: writes_o = 1'b1;
            default:                                 writes_o = 1'b0;
        endcase
        // jal links into r31 regardless of the rd field
        dest_o = (op == OP_JAL) ? LINK_REG : instr_i[RD_LSB +: FIELD_W];
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard unit: in-order FIFO of pending destination registers,
// pushed on issue, popped on writeback retire, trimmed on flush.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      d_instruction,
    input  logic             d_valid,
    input  logic             d_advance,
    input  logic [31:0]      w_instruction,
    input  logic             w_valid,
    input  logic             flush,
    input  logic [1:0]       flush_count,
    output logic             stall,
    output logic             issue,
    output logic [CNT_W-1:0] inflight_count,
    output logic             underflow_error
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             d_writes, w_writes;
    logic [4:0]       d_dest, w_dest;
    logic [4:0]       d_op, d_rs, d_rt, d_rd;
    logic             use_rs, use_rt, use_rd;

    logic [4:0]       dest_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic             pop_req, pop, push, empty, full, hazard, match, d_writer;
    logic [CNT_W-1:0] cnt_pop, trim;
    logic [PTR_W-1:0] off;

    dest_decode u_d_dest (
        .instr_i  (d_instruction),
        .writes_o (d_writes),
        .dest_o   (d_dest)
    );

    dest_decode u_w_dest (
        .instr_i  (w_instruction),
        .writes_o (w_writes),
        .dest_o   (w_dest)
    );

    assign d_op = d_instruction[OPC_LSB +: FIELD_W];
    assign d_rd = d_instruction[RD_LSB  +: FIELD_W];
    assign d_rs = d_instruction[RS_LSB  +: FIELD_W];
    assign d_rt = d_instruction[RT_LSB  +: FIELD_W];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        use_rd = 1'b0;
        case (d_op)
            OP_ALU:                begin use_rs = 1'b1; use_rt = 1'b1; end
            OP_ADDI, OP_LW:        use_rs = 1'b1;
            OP_SW, OP_BNE, OP_BLT: begin use_rs = 1'b1; use_rd = 1'b1; end
            OP_JR:                 use_rd = 1'b1;
            default:               ;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_req = w_valid & w_writes & (w_dest != 5'd0);
    assign pop     = pop_req & ~empty;

    // With a write-through register file the retiring head is already readable.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !(WB_BYPASS && pop && (PTR_W'(i) == head_q))) begin
                if ((use_rs && d_rs != 5'd0 && d_rs == dest_q[i]) ||
                    (use_rt && d_rt != 5'd0 && d_rt == dest_q[i]) ||
                    (use_rd && d_rd != 5'd0 && d_rd == dest_q[i]))
                    match = 1'b1;
            end
        end
    end

    assign hazard   = d_valid & match;
    assign d_writer = d_valid & d_writes & (d_dest != 5'd0);
    assign stall    = hazard | (d_writer & full);
    assign issue    = d_valid & d_advance & ~stall & ~flush;
    assign push     = issue & d_writes & (d_dest != 5'd0);

    always_comb begin
        cnt_pop = count_q - CNT_W'(pop);
        trim    = '0;
        if (flush)
            trim = (CNT_W'(flush_count) < cnt_pop) ? CNT_W'(flush_count) : cnt_pop;
        count_d = cnt_pop - trim + CNT_W'(push);
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q - PTR_W'(trim) + PTR_W'(push);
        err_d   = err_q | (pop_req & empty);
        off     = '0;
        // An entry is live when its distance from the new head is below the new count.
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head_d;
            vld_d[i] = (CNT_W'(off) < count_d);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            dest_q[tail_q] <= d_dest;
    end

    assign inflight_count  = count_q;
    assign underflow_error = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard with hand-computed expectations.
module tb_decode_scoreboard;
    import decode_scoreboard_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] d_instruction, w_instruction;
    logic        d_valid, d_advance, w_valid, flush;
    logic [1:0]  flush_count;
    logic        stall, issue, underflow_error;
    logic [2:0]  inflight_count;

    int tests = 0;
    int fails = 0;

    decode_scoreboard dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .d_instruction   (d_instruction),
        .d_valid         (d_valid),
        .d_advance       (d_advance),
        .w_instruction   (w_instruction),
        .w_valid         (w_valid),
        .flush           (flush),
        .flush_count     (flush_count),
        .stall           (stall),
        .issue           (issue),
        .inflight_count  (inflight_count),
        .underflow_error (underflow_error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ins(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        return {op, rd, rs, rt, 12'h000};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [31:0] di, logic dv, logic adv,
                         logic [31:0] wi, logic wv, logic fl, logic [1:0] fc);
        d_instruction = di;
        d_valid       = dv;
        d_advance     = adv;
        w_instruction = wi;
        w_valid       = wv;
        flush         = fl;
        flush_count   = fc;
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(32'h0, 0, 0, 32'h0, 0, 0, 2'd0);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_issue", issue, 0);
        chk("rst_count", inflight_count, 0);
        chk("rst_err", underflow_error, 0);
        tick;
        reset_n = 1'b1;

        // add r3,r1,r2 issues and is pushed
        drive(ins(OP_ALU, 3, 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("add_r3_issue", issue, 1);
        chk("add_r3_stall", stall, 0);
        tick;
        chk("cnt_after_r3", inflight_count, 1);

        // add r4,r3,r0 hazards on r3
        drive(ins(OP_ALU, 4, 3, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("raw_r3_stall", stall, 1);
        chk("raw_r3_issue", issue, 0);
        tick;
        chk("raw_r3_stall_hold", stall, 1);
        chk("raw_r3_cnt_hold", inflight_count, 1);

        // retire r3: bypass clears the stall in the same cycle
        drive(ins(OP_ALU, 4, 3, 0), 1, 1, ins(OP_ALU, 3, 1, 2), 1, 0, 2'd0);
        #1;
        chk("bypass_stall", stall, 0);
        chk("bypass_issue", issue, 1);
        tick;
        chk("push_pop_cnt", inflight_count, 1);

        drive(32'h0, 0, 0, ins(OP_ALU, 4, 3, 0), 1, 0, 2'd0);
        tick;
        chk("drain_r4_cnt", inflight_count, 0);
        chk("drain_r4_err", underflow_error, 0);

        // jal pushes r31, jr r31 waits for it
        drive(ins(OP_JAL, 0, 0, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("jal_issue", issue, 1);
        tick;
        chk("jal_cnt", inflight_count, 1);
        drive(ins(OP_JR, 31, 0, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("jr_stall", stall, 1);
        tick;
        chk("jr_stall_hold", stall, 1);
        drive(ins(OP_JR, 31, 0, 0), 1, 1, ins(OP_JAL, 0, 0, 0), 1, 0, 2'd0);
        #1;
        chk("jr_release_stall", stall, 0);
        chk("jr_release_issue", issue, 1);
        tick;
        chk("jr_cnt", inflight_count, 0);

        // fill to DEPTH
        for (int r = 10; r < 14; r++) begin
            drive(ins(OP_ALU, 5'(r), 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
            tick;
        end
        chk("full_cnt", inflight_count, 4);
        drive(ins(OP_ALU, 14, 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("full_stall", stall, 1);
        chk("full_issue", issue, 0);
        drive(ins(OP_ALU, 14, 1, 2), 1, 1, ins(OP_ALU, 10, 1, 2), 1, 0, 2'd0);
        #1;
        chk("full_pop_stall", stall, 1);
        tick;
        chk("full_pop_cnt", inflight_count, 3);
        drive(ins(OP_ALU, 14, 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("after_pop_issue", issue, 1);
        tick;
        chk("refill_cnt", inflight_count, 4);
        for (int r = 11; r < 15; r++) begin
            drive(32'h0, 0, 0, ins(OP_ALU, 5'(r), 1, 2), 1, 0, 2'd0);
            tick;
        end
        chk("drain_full_cnt", inflight_count, 0);
        chk("drain_full_err", underflow_error, 0);

        // r5,r6,r7 pending; pop r5 and flush two youngest
        for (int r = 5; r < 8; r++) begin
            drive(ins(OP_ALU, 5'(r), 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
            tick;
        end
        chk("flush_pre_cnt", inflight_count, 3);
        drive(ins(OP_ALU, 9, 1, 2), 1, 1, ins(OP_ALU, 5, 1, 2), 1, 1, 2'd2);
        #1;
        chk("flush_masks_issue", issue, 0);
        tick;
        chk("flush_cnt", inflight_count, 0);
        drive(ins(OP_ALU, 8, 6, 7), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("post_flush_stall", stall, 0);
        chk("post_flush_issue", issue, 1);
        tick;
        chk("post_flush_cnt", inflight_count, 1);
        // flush_count exceeds occupancy: clamps to empty
        drive(32'h0, 0, 0, 32'h0, 0, 1, 2'd3);
        tick;
        chk("flush_clamp_cnt", inflight_count, 0);

        // retire with empty FIFO
        drive(32'h0, 0, 0, ins(OP_ALU, 3, 1, 2), 1, 0, 2'd0);
        tick;
        chk("underflow_err", underflow_error, 1);
        chk("underflow_cnt", inflight_count, 0);
        drive(32'h0, 0, 0, 32'h0, 0, 0, 2'd0);
        tick;
        chk("underflow_sticky", underflow_error, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_err", underflow_error, 0);
        tick;
        reset_n = 1'b1;

        // r0 destinations and sources never hazard or push
        drive(ins(OP_ADDI, 0, 1, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("addi_r0_issue", issue, 1);
        tick;
        chk("addi_r0_cnt", inflight_count, 0);
        drive(ins(OP_ALU, 9, 1, 2), 1, 1, 32'h0, 0, 0, 2'd0);
        tick;
        chk("r9_cnt", inflight_count, 1);
        drive(ins(OP_ALU, 1, 0, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("r0_src_stall", stall, 0);
        drive(ins(OP_SW, 9, 1, 0), 1, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("sw_rd_stall", stall, 1);
        drive(ins(OP_SW, 9, 1, 0), 0, 1, 32'h0, 0, 0, 2'd0);
        #1;
        chk("bubble_no_stall", stall, 0);
        // retire with a dest that differs from the head still pops
        drive(32'h0, 0, 0, ins(OP_ALU, 2, 1, 1), 1, 0, 2'd0);
        tick;
        chk("mismatch_pop_cnt", inflight_count, 0);
        chk("mismatch_pop_err", underflow_error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
Decode-stage hazard unit and consumer of the writeback-stage destination decode.
- Holds an in-order FIFO of destination registers for instructions issued but not yet retired.
- Stalls decode when a source register of the decode instruction matches a pending destination.
- Push on issue from decode; pop when the writeback stage retires a register write; trim on branch/jump flush.

Parameters:
DEPTH, 4, max in-flight register writers (decode-to-writeback distance); power of two, >= 2
WB_BYPASS, 1, 1 = register file is write-through, so the entry popped this cycle does not cause a stall
CNT_W, 3, width of inflight_count; must equal clog2(DEPTH+1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
d_instruction  in  32  instruction in decode
d_valid  in  1  decode holds a real instruction (0 = bubble)
d_advance  in  1  execute can accept an instruction this cycle
w_instruction  in  32  instruction in writeback
w_valid  in  1  writeback holds a real instruction
flush  in  1  squash younger in-flight instructions (taken branch/jump)
flush_count  in  2  number of youngest FIFO entries to discard (0-3)
stall  out  1  hold decode/fetch this cycle (combinational)
issue  out  1  d_valid & d_advance & ~stall & ~flush (combinational)
inflight_count  out  CNT_W  valid FIFO entries (registered)
underflow_error  out  1  sticky: writeback retired a write while the FIFO was empty

Behaviour:
- Opcode is [31:27].
- Destination decode, shared by d_ and w_ sides:
  - writes = opcode in {00000, 00011, 00101, 01000, 11110}.
  - dest = 5'd31 if opcode = 00011 (jal), else [26:22].
  - dest 0 is never pushed or popped.
- Sources:
  - rs [21:17] for opcodes 00000, 00101, 01000, 00111, 00010, 00110.
  - rt [16:12] for 00000.
  - rd [26:22] as a source for 00111 (sw), 00010 (bne), 00110 (blt), 00100 (jr).
  - A source equal to r0 never hazards.
- pop = w_valid & writes(w) & dest(w) != 0.
  - The popped entry is the head.
  - If dest(w) differs from the head, pop anyway (in-order pipeline) with no error.
- hazard = d_valid & (a used source equals the dest of any valid entry).
  - When WB_BYPASS=1 and pop=1, the head entry is excluded from the compare.
- full = inflight_count == DEPTH (registered value). No same-cycle pop-to-push bypass.
- stall = hazard | (d_valid & writes(d) & dest(d) != 0 & full).
- push = issue & writes(d) & dest(d) != 0. Write dest at the tail.
- Sequential update order within one edge:
  1. Pop the head.
  2. Apply flush: discard min(flush_count, count_after_pop) youngest entries.
  3. Push (push is never active with flush, because issue masks it).
- Same-cycle push and pop: count unchanged, head and tail both advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is separate, so full and empty are unambiguous.
- Underflow: pop while count == 0 sets underflow_error. Pointers and count hold; error stays set until reset.
- Reset (asynchronous, reset_n low):
  - head = tail = 0, inflight_count = 0, underflow_error = 0, all entry valid bits 0.
  - stall and issue then follow their inputs combinationally (stall = 0 with empty FIFO).
  - Reset mid-operation discards all pending entries.
- Latency: a pushed entry can hazard the next decode instruction in the following cycle. A pop clears the hazard in the same cycle when WB_BYPASS=1, otherwise one cycle later.

Decomposition:
- Shared package: opcode constants (OP_ALU=00000, OP_JAL=00011, OP_ADDI=00101, OP_LW=01000, OP_SETX=11110, OP_SW=00111, OP_BNE=00010, OP_BLT=00110, OP_JR=00100), LINK_REG=31, and field bit positions.
- Sub-module dest_decode (instruction -> writes, dest), instantiated twice (d and w). Source-use decode stays inline.

Test Plan:
- Reset, then d=add r3,r1,r2, d_advance=1 -> issue=1, stall=0; next cycle inflight_count=1. d=add r4,r3,r0 -> stall=1 until w=add r3 retires; with WB_BYPASS=1, stall=0 in the retire cycle.
- d=jal -> entry r31 pushed; then d=jr r31 -> stall=1 until w=jal retires.
- Push 4 writers with no pop -> inflight_count=4, next writer stall=1; in a same-cycle pop, stall is still 1; the writer issues the following cycle.
- Count=3 (r5,r6,r7), flush=1, flush_count=2, pop in the same cycle -> count=0, head=tail; next d=add r8,r6,r7 has no stall.
- w_valid writer with count=0 -> underflow_error=1, count stays 0; error persists; reset_n low -> error=0.
- Sources equal to r0, and addi r0,... -> never stall, never push; sw r9 after add r9 -> stall on the rd source.
